// File: rtl/dmem_responder.sv
// dmem_responder
//   Single-port data memory responder. Accepts one load/store request at a
//   time, waits WAIT_CYCLES cycles, then presents a one-cycle response.
//   Stores update only the addressed byte lanes; loads return the full
//   aligned word. Misaligned, out-of-range or illegal-size requests return
//   resp_err with zero data and leave the memory untouched.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 4)
//   WAIT_CYCLES  wait states between acceptance and response (0..15)
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid / req_ready    request handshake
//   req_we, req_size         store flag; size 00 byte, 01 half, 10 word
//   req_addr, req_wdata      byte address, right-aligned store data
//   resp_valid               one-cycle response strobe
//   resp_rdata, resp_err     load word (0 for stores/errors), error flag
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  logic [31:0] mem [DEPTH_WORDS];

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        accept;
  logic        enter_resp;
  logic        op_we;
  logic [1:0]  op_size;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic        op_err;
  logic [AW-1:0] op_idx;
  logic [3:0]  op_be;
  logic [31:0] op_wlanes;
  logic        mem_we;

  assign req_ready  = (state_q == S_IDLE) && !rst;
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  assign accept = req_valid && req_ready;

  // With zero wait states the access completes on the acceptance edge, so
  // the live request fields are used; otherwise the latched copy is used.
  assign op_we    = (state_q == S_IDLE) ? req_we    : we_q;
  assign op_size  = (state_q == S_IDLE) ? req_size  : size_q;
  assign op_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
  assign op_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;

  assign enter_resp = ((state_q == S_IDLE) && accept && (WAIT_CYCLES == 0)) ||
                      ((state_q == S_WAIT) && (cnt_q == 4'd0));

  assign op_idx = op_addr[AW+1:2];
  assign op_err = (op_size == 2'b11) ||
                  ((op_size == 2'b01) && op_addr[0]) ||
                  ((op_size == 2'b10) && (op_addr[1:0] != 2'b00)) ||
                  (|op_addr[31:AW+2]);

  // Store data is replicated across lanes so the byte enables alone pick
  // the destination; no barrel shift is needed.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    op_be     = 4'b0000;
    op_wlanes = op_wdata;
    case (op_size)
      2'b00: begin
        op_be     = 4'b0001 << op_addr[1:0];
        op_wlanes = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        op_be     = op_addr[1] ? 4'b1100 : 4'b0011;
        op_wlanes = {2{op_wdata[15:0]}};
      end
      2'b10:   op_be = 4'b1111;
      default: op_be = 4'b0000;
    endcase
  end

  assign mem_we = enter_resp && op_we && !op_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = 32'h0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d    = req_we;
          size_d  = req_size;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Response fields are captured only on the edge entering RESP and fall
    // back to zero on the next edge, keeping them clean outside RESP.
    if (enter_resp) begin
      err_d   = op_err;
      rdata_d = (op_we || op_err) ? 32'h0 : mem[op_idx];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the storage array has no reset so it maps onto RAM; a reset
  // during WAIT still blocks the write because state is forced to IDLE.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (op_be[i]) mem[op_idx][8*i +: 8] <= op_wlanes[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//   Randomized and directed stimulus for dmem_responder. A byte-addressed
//   reference memory predicts each response; expectations are queued at
//   acceptance and a negedge monitor pops and compares them whenever the
//   DUT strobes resp_valid.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int WAIT  = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic [31:0] mask;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_cmp   = 0;
  int          n_bad   = 0;
  int          neg_cnt = 0;
  int          last_acc = 0;
  bit          busy    = 1'b0;
  logic [7:0]  mb [DEPTH*4];
  bit          mk [DEPTH*4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference model: flat byte memory with a known-byte map. Unwritten bytes
  // are excluded from the load comparison through the mask.
  task automatic model(input bit we, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, output exp_t e);
    int  nbytes;
    int  base;
    bit  err;
    nbytes  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err     = (size == 2'd3) || ((addr % nbytes) != 0) || (addr >= DEPTH * 4);
    e.err   = err;
    e.rdata = 32'h0;
    e.mask  = 32'hFFFF_FFFF;
    e.acc   = 0;
    if (!err && we) begin
      for (int i = 0; i < nbytes; i++) begin
        mb[addr + i] = wdata[8*i +: 8];
        mk[addr + i] = 1'b1;
      end
    end else if (!err) begin
      base   = addr - (addr % 4);
      e.mask = 32'h0;
      for (int i = 0; i < 4; i++) begin
        if (mk[base + i]) begin
          e.rdata[8*i +: 8] = mb[base + i];
          e.mask[8*i +: 8]  = 8'hFF;
        end
      end
    end
  endtask

  task automatic issue(input bit we, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit hold = 1'b0,
                       input bit use_exp = 1'b0, input logic [31:0] exp_rdata = 32'h0,
                       input bit exp_err = 1'b0);
    exp_t e;
    bit   done;
    done = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    for (int t = 0; t < 100 && !done; t++) begin
      if (req_ready) begin
        @(posedge clk);
        model(we, size, addr, wdata, e);
        if (use_exp) begin
          e.rdata = exp_rdata;
          e.err   = exp_err;
          e.mask  = 32'hFFFF_FFFF;
        end
        e.acc    = neg_cnt;
        last_acc = neg_cnt;
        sb.push_back(e);
        busy = 1'b1;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) check("accept_timeout", {31'b0, done}, 32'd1);
    if (!hold) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 50 && sb.size() > 0; t++) @(negedge clk);
    check("drain_pending", sb.size(), 32'd0);
  endtask

  // Monitor: compares responses, and outside responses checks that the
  // handshake and response outputs match the busy/idle expectation.
  always @(negedge clk) begin
    neg_cnt++;
    if (resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_resp_valid", {31'b0, resp_valid}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("resp_err", {31'b0, resp_err}, {31'b0, mon_e.err});
        check("resp_rdata", resp_rdata & mon_e.mask, mon_e.rdata & mon_e.mask);
        check("resp_latency", neg_cnt - mon_e.acc, WAIT + 1);
        check("ready_in_resp", {31'b0, req_ready}, 32'd0);
        busy = 1'b0;
      end
    end else if (busy) begin
      check("ready_while_busy", {31'b0, req_ready}, 32'd0);
    end else begin
      check("idle_err", {31'b0, resp_err}, 32'd0);
      check("idle_rdata", resp_rdata, 32'd0);
    end
  end

  initial begin
    logic [7:0]  save [4];
    logic [1:0]  sz;
    logic [31:0] ad;
    int          a0;
    int          r;

    for (int i = 0; i < DEPTH * 4; i++) begin
      mk[i] = 1'b0;
      mb[i] = 8'h00;
    end
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_size  = 2'b00;
    req_addr  = 32'h0;
    req_wdata = 32'h0;

    // Reset state
    @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {31'b0, req_ready}, 32'd1);

    // Word store then load, latency checked by the monitor
    issue(1'b1, 2'd2, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0, 1'b0);
    issue(1'b0, 2'd2, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);

    // Byte lanes, then a half overwriting the upper lanes
    issue(1'b1, 2'd0, 32'h20, 32'h11);
    issue(1'b1, 2'd0, 32'h21, 32'h22);
    issue(1'b1, 2'd0, 32'h22, 32'h33);
    issue(1'b1, 2'd0, 32'h23, 32'h44);
    issue(1'b1, 2'd1, 32'h22, 32'hAAAA);
    issue(1'b0, 2'd2, 32'h20, 32'h0, 1'b0, 1'b1, 32'hAAAA_2211, 1'b0);

    // Misaligned accesses error out and leave memory intact
    issue(1'b1, 2'd2, 32'h24, 32'hCAFE_F00D);
    issue(1'b1, 2'd2, 32'h26, 32'h5555_5555, 1'b0, 1'b1, 32'h0, 1'b1);
    issue(1'b0, 2'd1, 32'h21, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1);
    issue(1'b0, 2'd2, 32'h24, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0);

    // Out-of-range store does not alias onto word 0
    issue(1'b1, 2'd2, 32'h0, 32'h0102_0304);
    issue(1'b1, 2'd2, 32'h400, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0, 1'b1);
    issue(1'b0, 2'd2, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0102_0304, 1'b0);

    // Illegal size
    issue(1'b0, 2'd3, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1);

    // req_valid held high across three requests
    issue(1'b1, 2'd2, 32'h40, 32'h1111_1111, 1'b1);
    a0 = last_acc;
    issue(1'b1, 2'd2, 32'h44, 32'h2222_2222, 1'b1);
    check("accept_spacing_1", last_acc - a0, WAIT + 2);
    a0 = last_acc;
    issue(1'b0, 2'd2, 32'h40, 32'h0, 1'b1);
    check("accept_spacing_2", last_acc - a0, WAIT + 2);
    @(negedge clk);
    req_valid = 1'b0;
    drain();

    // Reset during WAIT aborts the store and suppresses the response
    issue(1'b1, 2'd2, 32'h30, 32'h0);
    drain();
    for (int i = 0; i < 4; i++) save[i] = mb[32'h30 + i];
    issue(1'b1, 2'd2, 32'h30, 32'h1234_5678);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    busy = 1'b0;
    for (int i = 0; i < 4; i++) mb[32'h30 + i] = save[i];
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_ready_low", {31'b0, req_ready}, 32'd0);
      check("rst_no_resp", {31'b0, resp_valid}, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_abort", {31'b0, req_ready}, 32'd1);
    issue(1'b0, 2'd2, 32'h30, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 150; n++) begin
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      if ($urandom_range(0, 9) == 0) ad = 32'h400 + 32'($urandom_range(0, 255));
      else                           ad = 32'($urandom_range(0, 63));
      issue(1'($urandom_range(0, 1)), sz, ad, $urandom);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
